sd_emmc_controller_adma2: RTL and testbench
===========================================

// Module: sd_emmc_controller_adma2
// PURPOSE
//  ADMA2 descriptor-table walker for the eMMC host DMA path. Fetches 64-bit descriptors over a dedicated
//  AXI read port and decodes them (nop/rsv/tran/link). Issues one segment (addr,len) per tran descriptor
//  to the SDMA datapath and waits for seg_done. Reports end, per-descriptor interrupt and ADMA error
//  state to the register file.
// PARAMETERS
//  MAX_DESC  1024  descriptors processed per run before a loop error is declared (>=1)
// PORTS
//  clock           in   1   system clock
//  reset           in   1   synchronous, active-low
//  adma_start      in   1   pulse: start walking at adma_desc_base (ignored unless IDLE)
//  adma_desc_base  in   32  descriptor table base address (8-byte aligned)
//  adma_abort      in   1   level: stop after current segment
//  desc_araddr     out  32  AXI AR address
//  desc_arvalid    out  1   AXI AR valid
//  desc_arready    in   1   AXI AR ready
//  desc_arlen      out  8   constant 8'd1 (2-beat, 32-bit INCR burst)
//  desc_rdata      in   32  AXI R data
//  desc_rvalid     in   1   AXI R valid
//  desc_rready     out  1   AXI R ready
//  desc_rlast      in   1   AXI R last
//  desc_rresp      in   2   AXI R response
//  seg_addr        out  32  segment system address to DMA datapath
//  seg_len         out  17  segment byte length (1..65536)
//  seg_start       out  1   one-cycle pulse, seg_addr/seg_len valid from this cycle until seg_done
//  seg_done        in   1   one-cycle pulse from datapath: segment finished
//  adma_busy       out  1   high in every state except IDLE
//  adma_done       out  1   one-cycle pulse: end descriptor processed
//  desc_int        out  1   one-cycle pulse: int-attribute descriptor completed
//  adma_err        out  1   sticky until next adma_start: ADMA error
//  adma_err_state  out  2   00 ST_STOP, 01 ST_FDS, 11 ST_TFR (SDHC 3.00 encoding)
//  cur_desc_addr   out  32  address of descriptor being processed (ADMA System Address reg)
// BEHAVIOUR
//  Reset: all outputs 0 except desc_arlen=1. State=IDLE, descriptor counter=0.
//  Descriptor: word0 (first beat) = {len[31:16], rsvd[15:6], act[5:4], rsvd[3], int[2], end[1], valid[0]}.
//   word1 = address. len==0 means 65536.
//  States:
//   IDLE: on adma_start latch cur_desc_addr=base; clear adma_err; err_state=01; count=0; go FETCH_A.
//   FETCH_A: arvalid=1, araddr=cur_desc_addr; hold until arready sampled high; then FETCH_D.
//   FETCH_D: rready=1. Beat0 -> word0 reg; beat1 -> word1 reg.
//    rlast on beat0, no rlast on beat1, or rresp!=0 -> ERROR.
//    Otherwise, after beat1, go DECODE.
//   DECODE (1 cycle):
//    valid==0 -> ERROR (err_state 01).
//    act 00/01 -> NEXT.
//    act 10 -> seg_addr=word1, seg_len, seg_start pulse, err_state=11, go XFER.
//    act 11 -> cur_desc_addr=word1, go CHECK (end ignored on link).
//    word1[1:0]!=0 on tran/link -> ERROR.
//   XFER: wait seg_done; then desc_int pulse if int; go NEXT. seg_done is ignored in every other state.
//   NEXT: if end -> adma_done pulse, err_state=00, go IDLE.
//    Else if adma_abort -> err_state=00, go IDLE without adma_done.
//    Else cur_desc_addr+=8 (mod 2^32), go CHECK.
//   CHECK: count+=1; if count==MAX_DESC -> ERROR, else FETCH_A.
//   ERROR: adma_err=1 for one cycle entering, then held sticky. err_state frozen. Go IDLE.
//  Abort:
//   Abort in FETCH_A/FETCH_D completes the AXI transaction first (no dropped AR/R beats).
//   It then goes IDLE with err_state=00 and no segment issued.
//  Timing: adma_start to arvalid = 1 cycle. Last R beat to seg_start = 2 cycles.
//   seg_done to next arvalid = 3 cycles.
//  adma_start while busy is ignored. Reset mid-burst drops the transaction (interconnect reset shared).
// TESTING
//  1. Base 0x1000, single tran len=0x200 addr=0x8000 end=1 -> one seg_start (0x8000,512), adma_done after seg_done.
//  2. Three tran descriptors, middle int=1 -> desc_araddr 0x1000/0x1008/0x1010; desc_int exactly once; adma_done once.
//  3. Link at 0x1000 to 0x2000; tran end at 0x2000 -> second fetch at 0x2000; no seg from link.
//  4. Descriptor valid=0 -> adma_err=1, err_state=01, no seg_start.
//  5. tran len=0 -> seg_len=65536. rresp=2'b10 on beat1 -> ERROR.
//  6. Self-link loop with MAX_DESC=4 -> ERROR after 4 fetches.
//     adma_abort during XFER -> waits seg_done, IDLE, no adma_done.

Source files
------------

// File: rtl/sd_emmc_controller_adma2_if.sv
// Descriptor-fetch AXI read channel (AR + R) between the ADMA2 walker and the
// interconnect. The master side issues reads; the slave side returns data.
interface sd_emmc_controller_adma2_if;
   logic [31:0] desc_araddr;
   logic        desc_arvalid;
   logic        desc_arready;
   logic [7:0]  desc_arlen;
   logic [31:0] desc_rdata;
   logic        desc_rvalid;
   logic        desc_rready;
   logic        desc_rlast;
   logic [1:0]  desc_rresp;

   modport master (
      output desc_araddr, desc_arvalid, desc_arlen, desc_rready,
      input  desc_arready, desc_rdata, desc_rvalid, desc_rlast, desc_rresp
   );

   modport slave (
      input  desc_araddr, desc_arvalid, desc_arlen, desc_rready,
      output desc_arready, desc_rdata, desc_rvalid, desc_rlast, desc_rresp
   );
endinterface

// File: rtl/sd_emmc_controller_adma2.sv
// ADMA2 descriptor-table walker: fetches 64-bit descriptors, issues one DMA
// segment per tran descriptor, follows links and reports end/int/error state.
module sd_emmc_controller_adma2 #(
   parameter int unsigned MAX_DESC = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        adma_start,
   input  logic [31:0] adma_desc_base,
   input  logic        adma_abort,
   sd_emmc_controller_adma2_if.master axi,
   output logic [31:0] seg_addr,
   output logic [16:0] seg_len,
   output logic        seg_start,
   input  logic        seg_done,
   output logic        adma_busy,
   output logic        adma_done,
   output logic        desc_int,
   output logic        adma_err,
   output logic [1:0]  adma_err_state,
   output logic [31:0] cur_desc_addr
);

   localparam int unsigned   CW      = $clog2(MAX_DESC + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DESC);
   localparam logic [1:0]    ES_STOP = 2'b00;
   localparam logic [1:0]    ES_FDS  = 2'b01;
   localparam logic [1:0]    ES_TFR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE, ST_FETCH_A, ST_FETCH_D, ST_DECODE,
      ST_XFER, ST_NEXT, ST_CHECK, ST_ERROR
   } state_t;

   state_t        state_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_inc_s;
   logic          beat_r;
   logic          abort_seen_r;
   logic [15:0]   d_len_r;
   logic [1:0]    d_act_r;
   logic          d_int_r;
   logic          d_end_r;
   logic          d_valid_r;
   logic [31:0]   word1_r;
   logic [31:0]   cur_addr_r;
   logic          arvalid_r;
   logic          rready_r;
   logic [31:0]   seg_addr_r;
   logic [16:0]   seg_len_r;
   logic          seg_start_r;
   logic          busy_r;
   logic          adma_done_r;
   logic          desc_int_r;
   logic          adma_err_r;
   logic [1:0]    err_state_r;
   logic [10:0]   rsvd_unused_s;

   // A zero length field encodes the full 64 KiB segment.
   function automatic logic [16:0] decode_len(input logic [15:0] len);
      if (len == 16'd0) begin
         return 17'h10000;
      end else begin
         return {1'b0, len};
      end
   endfunction

   // Reserved descriptor bits carry no meaning for this walker.
   assign rsvd_unused_s = {axi.desc_rdata[15:6], axi.desc_rdata[3]};
   assign count_inc_s   = count_r + CW'(1);

   assign axi.desc_araddr  = cur_addr_r;
   assign axi.desc_arvalid = arvalid_r;
   assign axi.desc_arlen   = 8'd1;
   assign axi.desc_rready  = rready_r;
   assign seg_addr         = seg_addr_r;
   assign seg_len          = seg_len_r;
   assign seg_start        = seg_start_r;
   assign adma_busy        = busy_r;
   assign adma_done        = adma_done_r;
   assign desc_int         = desc_int_r;
   assign adma_err         = adma_err_r;
   assign adma_err_state   = err_state_r;
   assign cur_desc_addr    = cur_addr_r;

   // Walker state machine with all outputs registered.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         count_r      <= '0;
         beat_r       <= 1'b0;
         abort_seen_r <= 1'b0;
         d_len_r      <= 16'd0;
         d_act_r      <= 2'b00;
         d_int_r      <= 1'b0;
         d_end_r      <= 1'b0;
         d_valid_r    <= 1'b0;
         word1_r      <= 32'd0;
         cur_addr_r   <= 32'd0;
         arvalid_r    <= 1'b0;
         rready_r     <= 1'b0;
         seg_addr_r   <= 32'd0;
         seg_len_r    <= 17'd0;
         seg_start_r  <= 1'b0;
         busy_r       <= 1'b0;
         adma_done_r  <= 1'b0;
         desc_int_r   <= 1'b0;
         adma_err_r   <= 1'b0;
         err_state_r  <= ES_STOP;
      end else begin
         seg_start_r <= 1'b0;
         adma_done_r <= 1'b0;
         desc_int_r  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (adma_start) begin
                  cur_addr_r   <= adma_desc_base;
                  adma_err_r   <= 1'b0;
                  err_state_r  <= ES_FDS;
                  count_r      <= '0;
                  abort_seen_r <= 1'b0;
                  arvalid_r    <= 1'b1;
                  busy_r       <= 1'b1;
                  state_r      <= ST_FETCH_A;
               end
            end
            ST_FETCH_A: begin
               abort_seen_r <= abort_seen_r | adma_abort;
               if (axi.desc_arready) begin
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
                  beat_r    <= 1'b0;
                  state_r   <= ST_FETCH_D;
               end
            end
            ST_FETCH_D: begin
               abort_seen_r <= abort_seen_r | adma_abort;
               if (axi.desc_rvalid) begin
                  if (!beat_r) begin
                     d_len_r   <= axi.desc_rdata[31:16];
                     d_act_r   <= axi.desc_rdata[5:4];
                     d_int_r   <= axi.desc_rdata[2];
                     d_end_r   <= axi.desc_rdata[1];
                     d_valid_r <= axi.desc_rdata[0];
                     if (axi.desc_rlast || (axi.desc_rresp != 2'b00)) begin
                        rready_r   <= 1'b0;
                        adma_err_r <= 1'b1;
                        state_r    <= ST_ERROR;
                     end else begin
                        beat_r <= 1'b1;
                     end
                  end else begin
                     word1_r  <= axi.desc_rdata;
                     rready_r <= 1'b0;
                     if (!axi.desc_rlast || (axi.desc_rresp != 2'b00)) begin
                        adma_err_r <= 1'b1;
                        state_r    <= ST_ERROR;
                     end else begin
                        state_r <= ST_DECODE;
                     end
                  end
               end
            end
            ST_DECODE: begin
               // An abort seen during the fetch wins over whatever was fetched.
               if (abort_seen_r || adma_abort) begin
                  err_state_r <= ES_STOP;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else if (!d_valid_r) begin
                  adma_err_r <= 1'b1;
                  state_r    <= ST_ERROR;
               end else begin
                  case (d_act_r)
                     2'b10: begin
                        if (word1_r[1:0] != 2'b00) begin
                           adma_err_r <= 1'b1;
                           state_r    <= ST_ERROR;
                        end else begin
                           seg_addr_r  <= word1_r;
                           seg_len_r   <= decode_len(d_len_r);
                           seg_start_r <= 1'b1;
                           err_state_r <= ES_TFR;
                           state_r     <= ST_XFER;
                        end
                     end
                     2'b11: begin
                        if (word1_r[1:0] != 2'b00) begin
                           adma_err_r <= 1'b1;
                           state_r    <= ST_ERROR;
                        end else begin
                           cur_addr_r <= word1_r;
                           state_r    <= ST_CHECK;
                        end
                     end
                     default: begin
                        state_r <= ST_NEXT;
                     end
                  endcase
               end
            end
            ST_XFER: begin
               if (seg_done) begin
                  desc_int_r <= d_int_r;
                  state_r    <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (d_end_r) begin
                  adma_done_r <= 1'b1;
                  err_state_r <= ES_STOP;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else if (adma_abort) begin
                  err_state_r <= ES_STOP;
                  busy_r      <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  cur_addr_r <= cur_addr_r + 32'd8;
                  state_r    <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               count_r <= count_inc_s;
               if (count_inc_s == MAX_CNT) begin
                  adma_err_r <= 1'b1;
                  state_r    <= ST_ERROR;
               end else begin
                  abort_seen_r <= 1'b0;
                  arvalid_r    <= 1'b1;
                  err_state_r  <= ES_FDS;
                  state_r      <= ST_FETCH_A;
               end
            end
            ST_ERROR: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_emmc_controller_adma2.sv
// Directed bench for the ADMA2 walker: a descriptor memory behind an AXI read
// responder, a segment datapath responder, and table-driven plus hand sequences.
module tb_sd_emmc_controller_adma2;

   logic        clock;
   logic        reset;
   logic        adma_start;
   logic [31:0] adma_desc_base;
   logic        adma_abort;
   logic [31:0] seg_addr;
   logic [16:0] seg_len;
   logic        seg_start;
   logic        seg_done;
   logic        adma_busy;
   logic        adma_done;
   logic        desc_int;
   logic        adma_err;
   logic [1:0]  adma_err_state;
   logic [31:0] cur_desc_addr;

   sd_emmc_controller_adma2_if axi ();

   sd_emmc_controller_adma2 #(.MAX_DESC(4)) dut (
      .clock          (clock),
      .reset          (reset),
      .adma_start     (adma_start),
      .adma_desc_base (adma_desc_base),
      .adma_abort     (adma_abort),
      .axi            (axi),
      .seg_addr       (seg_addr),
      .seg_len        (seg_len),
      .seg_start      (seg_start),
      .seg_done       (seg_done),
      .adma_busy      (adma_busy),
      .adma_done      (adma_done),
      .desc_int       (desc_int),
      .adma_err       (adma_err),
      .adma_err_state (adma_err_state),
      .cur_desc_addr  (cur_desc_addr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mem [logic [31:0]];
   logic        inj_rlast0 = 1'b0;
   logic [1:0]  inj_rresp1 = 2'b00;

   int          seg_cnt, done_cnt, int_cnt;
   logic [31:0] last_seg_addr;
   logic [16:0] last_seg_len;
   int          seg_cyc, beat1_cyc, seg_done_cyc, ar_gap;
   logic [31:0] fetch_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return 32'h0;
   endfunction

   // AXI read responder: one AR handshake, then one or two R beats
   initial begin : axi_slave
      logic [31:0] addr;
      logic        hs;
      axi.desc_arready = 1'b0;
      axi.desc_rvalid  = 1'b0;
      axi.desc_rdata   = 32'h0;
      axi.desc_rlast   = 1'b0;
      axi.desc_rresp   = 2'b00;
      forever begin
         @(posedge clock); #1;
         if (reset && axi.desc_arvalid) begin
            addr = axi.desc_araddr;
            axi.desc_arready = 1'b1;
            @(posedge clock); #1;
            axi.desc_arready = 1'b0;
            axi.desc_rvalid  = 1'b1;
            axi.desc_rdata   = mem_rd(addr);
            axi.desc_rlast   = inj_rlast0;
            axi.desc_rresp   = 2'b00;
            for (int k = 0; k < 50; k++) begin
               hs = axi.desc_rready;
               @(posedge clock); #1;
               if (hs) break;
            end
            if (!inj_rlast0) begin
               axi.desc_rdata = mem_rd(addr + 32'd4);
               axi.desc_rlast = 1'b1;
               axi.desc_rresp = inj_rresp1;
               beat1_cyc = cyc;
               for (int k = 0; k < 50; k++) begin
                  hs = axi.desc_rready;
                  @(posedge clock); #1;
                  if (hs) break;
               end
            end
            axi.desc_rvalid = 1'b0;
            axi.desc_rlast  = 1'b0;
            axi.desc_rresp  = 2'b00;
         end
      end
   end

   // Segment datapath: finishes each segment three cycles after it starts
   initial begin : seg_engine
      seg_done = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (reset && seg_start) begin
            repeat (3) @(posedge clock);
            #1;
            seg_done = 1'b1;
            seg_done_cyc = cyc;
            @(posedge clock); #1;
            seg_done = 1'b0;
         end
      end
   end

   // Event monitor: pulse counts, fetch addresses, cycle stamps
   initial begin : monitor
      logic arvalid_q;
      arvalid_q = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (seg_start) begin
            seg_cnt++;
            seg_cyc = cyc;
            last_seg_addr = seg_addr;
            last_seg_len = seg_len;
         end
         if (adma_done) done_cnt++;
         if (desc_int) int_cnt++;
         if (axi.desc_arvalid && !arvalid_q) begin
            fetch_q.push_back(axi.desc_araddr);
            ar_gap = cyc - seg_done_cyc;
         end
         arvalid_q = axi.desc_arvalid;
      end
   end

   task automatic start_run(input logic [31:0] base);
      seg_cnt = 0;
      done_cnt = 0;
      int_cnt = 0;
      fetch_q.delete();
      adma_desc_base = base;
      adma_start = 1'b1;
      @(posedge clock); #1;
      adma_start = 1'b0;
      check("start_arvalid", axi.desc_arvalid, 1);
      check("start_busy", adma_busy, 1);
      check("start_err_clear", adma_err, 0);
      check("start_err_state", adma_err_state, 2'b01);
   endtask

   task automatic finish_run();
      for (int i = 0; i < 3000; i++) begin
         if (!adma_busy) break;
         @(posedge clock); #1;
      end
      check("run_timeout_busy", adma_busy, 0);
      repeat (2) begin
         @(posedge clock); #1;
      end
   endtask

   task automatic wait_seg();
      for (int i = 0; i < 300; i++) begin
         if (seg_cnt >= 1) break;
         @(posedge clock); #1;
      end
      check("wait_seg_seen", (seg_cnt >= 1), 1);
   endtask

   function automatic logic [31:0] fq(input int k);
      return (k < fetch_q.size()) ? fetch_q[k] : 32'hDEAD_DEAD;
   endfunction

   typedef struct {
      logic [31:0] w0;
      logic [31:0] w1;
      logic        rlast0;
      logic [1:0]  rresp1;
      int          exp_seg;
      logic [31:0] exp_addr;
      logic [16:0] exp_len;
      int          exp_done;
      int          exp_int;
      logic        exp_err;
      logic [1:0]  exp_es;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] w0, input logic [31:0] w1, input logic rl0,
                               input logic [1:0] rr1, input int s, input logic [31:0] a,
                               input logic [16:0] l, input int d, input int it,
                               input logic e, input logic [1:0] es);
      vec_t v;
      v.w0 = w0; v.w1 = w1; v.rlast0 = rl0; v.rresp1 = rr1; v.exp_seg = s;
      v.exp_addr = a; v.exp_len = l; v.exp_done = d; v.exp_int = it;
      v.exp_err = e; v.exp_es = es;
      return v;
   endfunction

   initial begin : main
      vec_t        vt [8];
      logic [31:0] exp_f [3];
      reset = 1'b0;
      adma_start = 1'b0;
      adma_desc_base = 32'h0;
      adma_abort = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_araddr", axi.desc_araddr, 32'h0);
      check("rst_arvalid_rready", {axi.desc_arvalid, axi.desc_rready}, 2'b00);
      check("rst_arlen", axi.desc_arlen, 8'd1);
      check("rst_seg", {seg_addr, seg_len, seg_start}, 50'h0);
      check("rst_status", {adma_busy, adma_done, desc_int, adma_err, adma_err_state}, 6'h0);
      check("rst_cur_addr", cur_desc_addr, 32'h0);
      reset = 1'b1;
      @(posedge clock); #1;

      //            w0            w1           rl0   rresp1 seg addr          len       done int err   es
      vt[0] = mk(32'h0200_0023, 32'h0000_8000, 1'b0, 2'b00, 1, 32'h0000_8000, 17'd512,  1, 0, 1'b0, 2'b00);
      vt[1] = mk(32'h0200_0022, 32'h0000_8000, 1'b0, 2'b00, 0, 32'h0,         17'd0,    0, 0, 1'b1, 2'b01);
      vt[2] = mk(32'h0000_0027, 32'h0000_9000, 1'b0, 2'b00, 1, 32'h0000_9000, 17'h10000, 1, 1, 1'b0, 2'b00);
      vt[3] = mk(32'h0000_0003, 32'h0000_0000, 1'b0, 2'b00, 0, 32'h0,         17'd0,    1, 0, 1'b0, 2'b00);
      vt[4] = mk(32'h0000_0013, 32'h0000_0000, 1'b0, 2'b00, 0, 32'h0,         17'd0,    1, 0, 1'b0, 2'b00);
      vt[5] = mk(32'h0200_0023, 32'h0000_8002, 1'b0, 2'b00, 0, 32'h0,         17'd0,    0, 0, 1'b1, 2'b01);
      vt[6] = mk(32'h0200_0023, 32'h0000_8000, 1'b0, 2'b10, 0, 32'h0,         17'd0,    0, 0, 1'b1, 2'b01);
      vt[7] = mk(32'h0200_0023, 32'h0000_8000, 1'b1, 2'b00, 0, 32'h0,         17'd0,    0, 0, 1'b1, 2'b01);

      for (int i = 0; i < 8; i++) begin
         mem.delete();
         mem[32'h1000] = vt[i].w0;
         mem[32'h1004] = vt[i].w1;
         inj_rlast0 = vt[i].rlast0;
         inj_rresp1 = vt[i].rresp1;
         start_run(32'h1000);
         finish_run();
         inj_rlast0 = 1'b0;
         inj_rresp1 = 2'b00;
         check($sformatf("vec%0d_seg_cnt", i), seg_cnt, vt[i].exp_seg);
         if (vt[i].exp_seg > 0) begin
            check($sformatf("vec%0d_seg_addr", i), last_seg_addr, vt[i].exp_addr);
            check($sformatf("vec%0d_seg_len", i), last_seg_len, vt[i].exp_len);
         end
         check($sformatf("vec%0d_done_cnt", i), done_cnt, vt[i].exp_done);
         check($sformatf("vec%0d_int_cnt", i), int_cnt, vt[i].exp_int);
         check($sformatf("vec%0d_err", i), adma_err, vt[i].exp_err);
         check($sformatf("vec%0d_err_state", i), adma_err_state, vt[i].exp_es);
         check($sformatf("vec%0d_fetches", i), fetch_q.size(), 1);
      end

      // Three tran descriptors, int on the middle one, plus an ignored start
      mem.delete();
      mem[32'h1000] = 32'h0040_0021; mem[32'h1004] = 32'h0000_8000;
      mem[32'h1008] = 32'h0080_0025; mem[32'h100C] = 32'h0000_8100;
      mem[32'h1010] = 32'h0010_0023; mem[32'h1014] = 32'h0000_8200;
      start_run(32'h1000);
      wait_seg();
      adma_desc_base = 32'h5000;
      adma_start = 1'b1;
      @(posedge clock); #1;
      adma_start = 1'b0;
      finish_run();
      exp_f = '{32'h1000, 32'h1008, 32'h1010};
      check("multi_fetches", fetch_q.size(), 3);
      for (int k = 0; k < 3; k++) check($sformatf("multi_araddr%0d", k), fq(k), exp_f[k]);
      check("multi_seg_cnt", seg_cnt, 3);
      check("multi_last_seg", {last_seg_addr, last_seg_len}, {32'h0000_8200, 17'h00010});
      check("multi_int_cnt", int_cnt, 1);
      check("multi_done_cnt", done_cnt, 1);
      check("multi_cur_addr", cur_desc_addr, 32'h1010);
      check("beat_to_seg_cycles", seg_cyc - beat1_cyc, 2);
      check("done_to_ar_cycles", ar_gap, 3);

      // Link at 0x1000 to a tran/end descriptor at 0x2000
      mem.delete();
      mem[32'h1000] = 32'h0000_0031; mem[32'h1004] = 32'h0000_2000;
      mem[32'h2000] = 32'h0100_0023; mem[32'h2004] = 32'h0000_A000;
      start_run(32'h1000);
      finish_run();
      check("link_fetches", fetch_q.size(), 2);
      check("link_second_fetch", fq(1), 32'h2000);
      check("link_seg_cnt", seg_cnt, 1);
      check("link_seg", {last_seg_addr, last_seg_len}, {32'h0000_A000, 17'd256});
      check("link_done_cnt", done_cnt, 1);
      check("link_cur_addr", cur_desc_addr, 32'h2000);

      // Self-link loop runs into the descriptor limit
      mem.delete();
      mem[32'h3000] = 32'h0000_0031; mem[32'h3004] = 32'h0000_3000;
      start_run(32'h3000);
      finish_run();
      check("loop_fetches", fetch_q.size(), 4);
      check("loop_last_fetch", fq(3), 32'h3000);
      check("loop_err", adma_err, 1);
      check("loop_err_state", adma_err_state, 2'b01);
      check("loop_seg_cnt", seg_cnt, 0);

      // Abort raised while a segment is in flight
      mem.delete();
      mem[32'h1000] = 32'h0040_0021; mem[32'h1004] = 32'h0000_8000;
      mem[32'h1008] = 32'h0040_0023; mem[32'h100C] = 32'h0000_8100;
      start_run(32'h1000);
      wait_seg();
      adma_abort = 1'b1;
      finish_run();
      adma_abort = 1'b0;
      check("xabort_seg_cnt", seg_cnt, 1);
      check("xabort_done_cnt", done_cnt, 0);
      check("xabort_fetches", fetch_q.size(), 1);
      check("xabort_err", {adma_err, adma_err_state}, 3'b000);

      // Abort raised during the descriptor fetch
      adma_abort = 1'b1;
      start_run(32'h1000);
      finish_run();
      adma_abort = 1'b0;
      check("fabort_seg_cnt", seg_cnt, 0);
      check("fabort_done_cnt", done_cnt, 0);
      check("fabort_fetches", fetch_q.size(), 1);
      check("fabort_err", {adma_err, adma_err_state}, 3'b000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
